// File: rtl/writeback_buffer_pkg.sv
// Constants shared by the writeback buffer and the register file.
package writeback_buffer_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned DATA_WIDTH     = 32;

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/writeback_forward.sv
// Youngest-match search over the pending entries for one read port.
// Register zero always reads as zero.
module writeback_forward
   import writeback_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_reg,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     entry_data,
   input  logic [$clog2(DEPTH)-1:0]             head,
   input  logic [$clog2(DEPTH):0]               count,
   input  logic [REG_ADDR_WIDTH-1:0]            read_register,
   input  logic [DATA_WIDTH-1:0]                rf_data,
   output logic [DATA_WIDTH-1:0]                read_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] idx;

   // Walk from oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      read_data = rf_data;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (entry_reg[idx] == read_register)) begin
            read_data = entry_data[idx];
         end
      end
      if (read_register == ZERO_REG) begin
         read_data = '0;
      end
   end

endmodule

// File: rtl/writeback_buffer.sv
// FIFO of pending register-file writes, drained when the write port is free,
// with read-port forwarding of pending data.
module writeback_buffer
   import writeback_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          InValid,
   output logic                          InReady,
   input  logic [REG_ADDR_WIDTH-1:0]     InRegister,
   input  logic [DATA_WIDTH-1:0]         InData,
   input  logic                          DrainEnable,
   output logic [REG_ADDR_WIDTH-1:0]     WriteRegister,
   output logic [DATA_WIDTH-1:0]         WriteData,
   output logic                          RegWrite,
   input  logic [REG_ADDR_WIDTH-1:0]     ReadRegister1,
   input  logic [REG_ADDR_WIDTH-1:0]     ReadRegister2,
   input  logic [DATA_WIDTH-1:0]         RfData1,
   input  logic [DATA_WIDTH-1:0]         RfData2,
   output logic [DATA_WIDTH-1:0]         ReadData1,
   output logic [DATA_WIDTH-1:0]         ReadData2,
   output logic [$clog2(DEPTH):0]        Count,
   output logic                          Empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] reg_mem_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_mem_q;
   logic [PW-1:0]                        head_q;
   logic [PW-1:0]                        tail_q;
   logic [CW-1:0]                        count_q;
   logic                                 push;
   logic                                 pop;

   always_comb begin
      InReady       = (count_q < CW'(DEPTH));
      Empty         = (count_q == '0);
      Count         = count_q;
      // Register-zero requests complete the handshake but never occupy an entry.
      push          = InValid && InReady && (InRegister != ZERO_REG);
      pop           = !Empty && DrainEnable;
      RegWrite      = pop;
      WriteRegister = Empty ? '0 : reg_mem_q[head_q];
      WriteData     = Empty ? '0 : data_mem_q[head_q];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            reg_mem_q[tail_q]  <= InRegister;
            data_mem_q[tail_q] <= InData;
            tail_q             <= tail_q + 1'b1;
         end
         if (pop) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   writeback_forward #(
      .DEPTH (DEPTH)
   ) u_forward1 (
      .entry_reg     (reg_mem_q),
      .entry_data    (data_mem_q),
      .head          (head_q),
      .count         (count_q),
      .read_register (ReadRegister1),
      .rf_data       (RfData1),
      .read_data     (ReadData1)
   );

   writeback_forward #(
      .DEPTH (DEPTH)
   ) u_forward2 (
      .entry_reg     (reg_mem_q),
      .entry_data    (data_mem_q),
      .head          (head_q),
      .count         (count_q),
      .read_register (ReadRegister2),
      .rf_data       (RfData2),
      .read_data     (ReadData2)
   );

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based model of the pending writes.
module tb_writeback_buffer;

   localparam int unsigned DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRegister;
   logic [31:0] InData;
   logic        DrainEnable;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] RfData1;
   logic [31:0] RfData2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [2:0]  Count;
   logic        Empty;

   int tests  = 0;
   int failed = 0;

   // Model: pending writes, oldest at index 0.
   logic [4:0]  m_reg[$];
   logic [31:0] m_data[$];

   always #5 Clk = ~Clk;

   writeback_buffer #(
      .DEPTH (DEPTH)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InRegister    (InRegister),
      .InData        (InData),
      .DrainEnable   (DrainEnable),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .RfData1       (RfData1),
      .RfData2       (RfData2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Count         (Count),
      .Empty         (Empty)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] rr, input logic [31:0] rf);
      if (rr == 5'd0) return 32'd0;
      for (int i = m_reg.size() - 1; i >= 0; i--) begin
         if (m_reg[i] == rr) return m_data[i];
      end
      return rf;
   endfunction

   // One clock cycle: drive, check combinational view, clock, update model.
   task automatic step(input logic rst, input logic v, input logic [4:0] rg,
                       input logic [31:0] d, input logic drain,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] f1, input logic [31:0] f2);
      int  n;
      bit  do_pop;
      bit  do_push;
      @(negedge Clk);
      Reset = rst; InValid = v; InRegister = rg; InData = d; DrainEnable = drain;
      ReadRegister1 = r1; ReadRegister2 = r2; RfData1 = f1; RfData2 = f2;
      #1;
      n = m_reg.size();
      check_eq("in_ready", 32'(InReady), 32'(n < DEPTH));
      check_eq("count", 32'(Count), 32'(n));
      check_eq("empty", 32'(Empty), 32'(n == 0));
      check_eq("reg_write", 32'(RegWrite), 32'(n > 0 && drain));
      check_eq("write_register", 32'(WriteRegister), (n > 0) ? 32'(m_reg[0]) : 32'd0);
      check_eq("write_data", WriteData, (n > 0) ? m_data[0] : 32'd0);
      check_eq("read_data1", ReadData1, model_read(r1, f1));
      check_eq("read_data2", ReadData2, model_read(r2, f2));
      do_pop  = (n > 0) && drain;
      do_push = v && (n < DEPTH) && (rg != 5'd0);
      @(posedge Clk);
      if (rst) begin
         m_reg.delete();
         m_data.delete();
      end else begin
         if (do_pop) begin
            void'(m_reg.pop_front());
            void'(m_data.pop_front());
         end
         if (do_push) begin
            m_reg.push_back(rg);
            m_data.push_back(d);
         end
      end
      #1;
   endtask

   task automatic idle(input logic drain);
      step(1'b0, 1'b0, 5'd0, 32'd0, drain, 5'd0, 5'd0, 32'd0, 32'd0);
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InRegister = '0; InData = '0; DrainEnable = 1'b0;
      ReadRegister1 = '0; ReadRegister2 = '0; RfData1 = '0; RfData2 = '0;
      repeat (2) @(posedge Clk);
      #1;

      // Reset then idle.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0, 32'h5555_0003, 32'h7);
      repeat (3) idle(1'b0);
      check_eq("post_reset_count", 32'(Count), 32'd0);
      check_eq("post_reset_regwrite", 32'(RegWrite), 32'd0);
      check_eq("post_reset_in_ready", 32'(InReady), 32'd1);
      check_eq("post_reset_empty", 32'(Empty), 32'd1);

      // Single write, forwarded before and during commit.
      step(1'b0, 1'b1, 5'd17, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd17, 32'd0, 32'h0BAD_0BAD);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd17, 32'd0, 32'h0BAD_0BAD);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd17, 32'd0, 32'hDEAD_BEEF);
      check_eq("single_done_empty", 32'(Empty), 32'd1);

      // Register-zero request is swallowed.
      step(1'b0, 1'b1, 5'd0, 32'd50, 1'b1, 5'd0, 5'd0, 32'h1234_5678, 32'h9);
      check_eq("zero_reg_count", 32'(Count), 32'd0);
      idle(1'b1);

      // Fill to full, hold a fifth request, then drain in order.
      for (int i = 1; i <= 4; i++)
         step(1'b0, 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 5'(i), 5'd2, 32'd0, 32'd0);
      check_eq("full_count", 32'(Count), 32'd4);
      check_eq("full_in_ready", 32'(InReady), 32'd0);
      step(1'b0, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd9, 5'd4, 32'h99, 32'd0);
      check_eq("full_held_count", 32'(Count), 32'd4);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check_eq("drained_empty", 32'(Empty), 32'd1);

      // Two writes to one register: youngest wins; push and pop together.
      step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'd0);
      step(1'b0, 1'b1, 5'd5, 32'h22, 1'b0, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'd0);
      check_eq("dup_count", 32'(Count), 32'd2);
      check_eq("dup_forward", ReadData1, 32'h22);
      step(1'b0, 1'b1, 5'd6, 32'h33, 1'b1, 5'd5, 5'd6, 32'hFFFF_FFFF, 32'd0);
      check_eq("push_pop_count", 32'(Count), 32'd2);
      repeat (3) idle(1'b1);

      // Reset discards pending entries.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 5'(10 + i), 32'hC0 + 32'(i), 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
      step(1'b1, 1'b1, 5'd20, 32'hEE, 1'b1, 5'd10, 5'd11, 32'h1, 32'h2);
      check_eq("reset_flush_count", 32'(Count), 32'd0);
      repeat (2) idle(1'b1);

      // Random traffic over a small register range to provoke matches.
      for (int c = 0; c < 3000; c++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
              5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
